// File: rtl/result_mem_reader.sv
// Result memory written by ALU pipeline stage 4, drained by a block-read engine
// that streams base_addr..base_addr+count-1 over a valid/ready handshake.
module result_mem_reader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 2 ** ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   count,
    output logic              busy,
    output logic              done,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_addr
);

    typedef enum logic [1:0] {IDLE, FETCH, PRESENT} state_t;

    state_t state_reg, state_next;

    logic [DATA_W-1:0] mem [DEPTH];

    logic [ADDR_W-1:0] ptr_reg, ptr_next;
    logic [ADDR_W:0]   remaining_reg, remaining_next;
    logic [DATA_W-1:0] out_data_reg, out_data_next;
    logic [ADDR_W-1:0] out_addr_reg, out_addr_next;
    logic              out_valid_reg, out_valid_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic [DATA_W-1:0] rd_word;

    // Memory has no reset so its contents survive rst_n.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Write-first: a same-cycle write to the fetched address wins.
    assign rd_word = (wr_en && (wr_addr == ptr_reg)) ? wr_data : mem[ptr_reg];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            ptr_reg       <= '0;
            remaining_reg <= '0;
            out_data_reg  <= '0;
            out_addr_reg  <= '0;
            out_valid_reg <= 1'b0;
            busy_reg      <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            ptr_reg       <= ptr_next;
            remaining_reg <= remaining_next;
            out_data_reg  <= out_data_next;
            out_addr_reg  <= out_addr_next;
            out_valid_reg <= out_valid_next;
            busy_reg      <= busy_next;
            done_reg      <= done_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        ptr_next       = ptr_reg;
        remaining_next = remaining_reg;
        out_data_next  = out_data_reg;
        out_addr_next  = out_addr_reg;
        out_valid_next = out_valid_reg;
        busy_next      = busy_reg;
        done_next      = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    if (count != '0) begin
                        state_next     = FETCH;
                        ptr_next       = base_addr;
                        remaining_next = count;
                        busy_next      = 1'b1;
                    end else begin
                        done_next = 1'b1;
                    end
                end
            end
            FETCH: begin
                state_next     = PRESENT;
                out_data_next  = rd_word;
                out_addr_next  = ptr_reg;
                out_valid_next = 1'b1;
            end
            PRESENT: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    remaining_next = remaining_reg - (ADDR_W + 1)'(1);
                    if (remaining_reg == (ADDR_W + 1)'(1)) begin
                        state_next = IDLE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        // Address arithmetic wraps naturally at DEPTH.
                        ptr_next   = ptr_reg + ADDR_W'(1);
                        state_next = FETCH;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_addr  = out_addr_reg;

endmodule

// File: tb/tb_result_mem_reader.sv
// Randomized self-checking bench for result_mem_reader against an array-based
// model of memory contents and the expected block stream.
module tb_result_mem_reader;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 256;

    logic              clk;
    logic              rst_n;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [ADDR_W:0]   count;
    logic              busy;
    logic              done;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W-1:0] out_addr;

    logic [DATA_W-1:0] model_mem [DEPTH];
    int n_checks;
    int n_fail;

    result_mem_reader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .start(start), .base_addr(base_addr), .count(count),
        .busy(busy), .done(done), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_addr(out_addr)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en = 1'b0;
        model_mem[a] = d;
    endtask

    // Streams a block and checks every presented word against the model.
    // hold_start keeps start asserted (with junk base/count) while busy.
    task automatic run_block(input logic [ADDR_W-1:0] b, input int cnt,
                             input int ready_pct, input bit hold_start, input string tag);
        int k;
        int cycles;
        int budget;
        bit hs;
        logic [ADDR_W-1:0] exp_addr;
        budget = 20 * cnt + 20;
        base_addr = b;
        count = (ADDR_W + 1)'(cnt);
        start = 1'b1;
        tick();
        if (!hold_start) start = 1'b0;
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_start: got %b want 1", tag, busy);
        end
        k = 0;
        cycles = 0;
        while (k < cnt && cycles < budget) begin
            if (hold_start) begin
                base_addr = ADDR_W'($urandom);
                count = (ADDR_W + 1)'($urandom_range(256));
            end
            n_checks++;
            if (busy !== 1'b1 || (done === 1'b1 && out_valid === 1'b1)) begin
                n_fail++;
                $display("FAIL %s busy_done: busy=%b done=%b valid=%b want busy=1 and not done&valid",
                         tag, busy, done, out_valid);
            end
            out_ready = ($urandom_range(99) < ready_pct);
            if (out_valid === 1'b1) begin
                exp_addr = b + ADDR_W'(k);
                n_checks++;
                if (out_addr !== exp_addr || out_data !== model_mem[exp_addr]) begin
                    n_fail++;
                    $display("FAIL %s word%0d: got addr=%h data=%h want addr=%h data=%h",
                             tag, k, out_addr, out_data, exp_addr, model_mem[exp_addr]);
                end
            end
            hs = (out_valid === 1'b1) && out_ready;
            tick();
            if (hs) k++;
            cycles++;
        end
        start = 1'b0;
        out_ready = 1'b0;
        if (k < cnt) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s timeout: got %0d words want %0d", tag, k, cnt);
        end
        if (ready_pct >= 100) begin
            n_checks++;
            if (cycles !== 2 * cnt) begin
                n_fail++;
                $display("FAIL %s throughput: got %0d cycles want %0d", tag, cycles, 2 * cnt);
            end
        end
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL %s completion: got done=%b busy=%b valid=%b want 1 0 0",
                     tag, done, busy, out_valid);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_pulse_width: got done=%b busy=%b want 0 0", tag, done, busy);
        end
        $display("block %s base=%h count=%0d words=%0d cycles=%0d", tag, b, cnt, k, cycles);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== '0 || out_addr !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got busy=%b done=%b valid=%b data=%h addr=%h want all 0",
                     busy, done, out_valid, out_data, out_addr);
        end
        #3 rst_n = 1'b1;
        tick();
        $display("reset: busy=%b done=%b valid=%b", busy, done, out_valid);
    endtask

    task automatic init_mem();
        for (int i = 0; i < DEPTH; i++) begin
            do_write(ADDR_W'(i), DATA_W'($urandom));
        end
    endtask

    task automatic test_block_read();
        do_write(8'h10, 16'h1111);
        do_write(8'h11, 16'h2222);
        do_write(8'h12, 16'h3333);
        do_write(8'h13, 16'h4444);
        run_block(8'h10, 4, 100, 1'b0, "basic");
    endtask

    task automatic test_backpressure();
        base_addr = 8'h10;
        count = 9'd2;
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 16'h1111 || out_addr !== 8'h10) begin
                n_fail++;
                $display("FAIL backpressure_hold%0d: got valid=%b data=%h addr=%h want 1 1111 10",
                         i, out_valid, out_data, out_addr);
            end
            tick();
        end
        out_ready = 1'b1;
        tick();
        tick();
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'h2222) begin
            n_fail++;
            $display("FAIL backpressure_second: got valid=%b data=%h want 1 2222", out_valid, out_data);
        end
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL backpressure_done: got done=%b valid=%b want 1 0", done, out_valid);
        end
        tick();
        $display("backpressure: block complete");
    endtask

    task automatic test_wrap();
        do_write(8'hFE, 16'hAAAA);
        do_write(8'hFF, 16'hBBBB);
        do_write(8'h00, 16'hCCCC);
        run_block(8'hFE, 3, 100, 1'b0, "wrap");
    endtask

    task automatic test_collision();
        do_write(8'h20, 16'h0001);
        base_addr = 8'h20;
        count = 9'd1;
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        wr_en = 1'b1;
        wr_addr = 8'h20;
        wr_data = 16'hBEEF;
        tick();
        model_mem[8'h20] = 16'hBEEF;
        wr_data = 16'h1234;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL collision_fetch: got valid=%b data=%h want 1 beef", out_valid, out_data);
        end
        tick();
        wr_en = 1'b0;
        model_mem[8'h20] = 16'h1234;
        n_checks++;
        if (out_valid !== 1'b1 || out_data !== 16'hBEEF) begin
            n_fail++;
            $display("FAIL collision_present: got valid=%b data=%h want 1 beef", out_valid, out_data);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL collision_done: got done=%b want 1", done);
        end
        tick();
        run_block(8'h20, 1, 100, 1'b0, "collision_readback");
    endtask

    task automatic test_count_zero();
        base_addr = 8'h33;
        count = 9'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL count_zero: got done=%b busy=%b valid=%b want 1 0 0", done, busy, out_valid);
        end
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL count_zero_after: got done=%b busy=%b valid=%b want 0 0 0", done, busy, out_valid);
        end
        $display("count_zero: done pulse seen");
    endtask

    task automatic test_back_to_back();
        run_block(8'h10, 4, 100, 1'b1, "start_while_busy");
        for (int i = 0; i < 10; i++) begin
            for (int w = 0; w < 3; w++) begin
                do_write(ADDR_W'($urandom), DATA_W'($urandom));
            end
            run_block(ADDR_W'($urandom), $urandom_range(40, 1), $urandom_range(100, 30), 1'b0, "random");
        end
        run_block(8'hC7, 256, 100, 1'b0, "full256");
    endtask

    task automatic test_reset_midblock();
        base_addr = 8'h10;
        count = 9'd4;
        start = 1'b1;
        out_ready = 1'b0;
        tick();
        start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_midblock: got valid=%b busy=%b data=%h done=%b want 0 0 0000 0",
                     out_valid, busy, out_data, done);
        end
        tick();
        #3 rst_n = 1'b1;
        tick();
        n_checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: got done=%b busy=%b want 0 0", done, busy);
        end
        $display("reset_midblock: aborted");
        run_block(8'h10, 4, 100, 1'b0, "post_reset");
        run_block(8'hFE, 3, 60, 1'b0, "post_reset_wrap");
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        start = 1'b0;
        base_addr = '0;
        count = '0;
        out_ready = 1'b0;
        test_reset();
        init_mem();
        test_block_read();
        test_backpressure();
        test_wrap();
        test_collision();
        test_count_zero();
        test_back_to_back();
        test_reset_midblock();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/result_mem_reader.md
Name: result_mem_reader

Overview:
- Holds the 256 x 16 result memory that the ALU pipeline's final stage writes into, and drains it back out.
- Write side: the pipeline's stage-4 write port, one word per cycle.
- Read side: a block-read engine. Given a base address and word count, it streams the stored results out over a valid/ready handshake, for the testbench or a downstream consumer.

Parameters:
- DATA_W, 16, result word width
- ADDR_W, 8, memory address width
- DEPTH, 256, number of words (2**ADDR_W)

Ports:
- clk  input  1  single system clock, all logic on rising edge
- rst_n  input  1  asynchronous active-low reset
- wr_en  input  1  write strobe from pipeline stage 4
- wr_addr  input  ADDR_W  write address
- wr_data  input  DATA_W  write data
- start  input  1  begin block read (sampled only in IDLE)
- base_addr  input  ADDR_W  first address of block
- count  input  ADDR_W+1  number of words, 0..256
- busy  output  1  block read in progress
- done  output  1  one-cycle pulse when a block completes
- out_valid  output  1  out_data/out_addr hold a word
- out_ready  input  1  consumer accepts word
- out_data  output  DATA_W  streamed word
- out_addr  output  ADDR_W  address of streamed word

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, out_valid=0, out_data=0, out_addr=0, internal remaining/pointer cleared.
  - Memory contents are NOT cleared or altered by reset.
- Write port:
  - wr_en=1 writes wr_data to mem[wr_addr] at the rising edge.
  - Writes are accepted in every state, including during a block read.
- FSM states: IDLE, FETCH, PRESENT.
  - IDLE -> FETCH: start=1 with count!=0 at edge E. Latch ptr=base_addr and remaining=count; busy=1 from E.
  - IDLE, start=1 with count=0: stay IDLE; done=1 for the cycle after E; busy stays 0.
  - FETCH -> PRESENT: at the next edge, out_data<=mem[ptr], out_addr<=ptr, out_valid<=1.
    - First word is visible one cycle after the start edge.
  - PRESENT holds while out_ready=0. out_data/out_addr stay stable; out_valid stays 1.
  - PRESENT with out_valid & out_ready at an edge (handshake): remaining decrements, out_valid<=0.
    - If remaining was 1: go IDLE, busy<=0, done<=1 for exactly one cycle.
    - Else: ptr<=ptr+1 modulo DEPTH (255 wraps to 0), go FETCH.
- Throughput: one word per 2 cycles with out_ready held high.
- start is ignored while busy=1. base_addr and count are only sampled at the accepting edge.
- Collision rules:
  - FETCH with wr_en=1 and wr_addr==ptr: write-first. out_data gets the new wr_data.
  - A write to out_addr during PRESENT does not change the presented out_data.
- count=256 reads every word once, wrapping from base_addr back to base_addr-1.
- Reset asserted mid-block: abort immediately, out_valid drops asynchronously, no done pulse; memory retained.
- done and out_valid are never high in the same cycle.

Test Plan:
- Write mem[0x10..0x13]=0x1111,0x2222,0x3333,0x4444. start, base=0x10, count=4, out_ready=1 -> four words in order with out_addr 0x10..0x13; handshakes 2 cycles apart; done pulses one cycle after the 4th handshake; busy low in that same cycle.
- Backpressure: count=2 at base 0x10, out_ready=0 for 5 cycles after first valid -> out_data held at 0x1111 and out_valid held at 1 throughout; releasing out_ready yields 0x2222 next, then done.
- Wrap: mem[0xFE]=0xAAAA, mem[0xFF]=0xBBBB, mem[0x00]=0xCCCC; base=0xFE, count=3 -> out_addr 0xFE,0xFF,0x00 with data AAAA,BBBB,CCCC.
- Collision: during FETCH of addr 0x20 (old 0x0001), wr_en with wr_addr=0x20, wr_data=0xBEEF -> out_data=0xBEEF. A write to 0x20 during PRESENT leaves out_data=0xBEEF until the handshake.
- count=0 start -> busy stays 0, out_valid never rises, done=1 for one cycle. A start asserted while busy is ignored and the current block completes unchanged.
- Reset mid-block: rst_n=0 while PRESENT -> out_valid, busy, out_data go 0 without waiting for a clock edge. After release, reading back earlier-written addresses returns the pre-reset contents.
